// File: rtl/ped_pkg.sv
// ped_pkg: shared definitions for the pedestrian request unit and the
// traffic light controller it talks to.
//   ped_state_e           - request-unit FSM state encoding
//   DEF_*                 - default parameter values
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WALK     = 2'd2,
        COOLDOWN = 2'd3
    } ped_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_WALK_CYCLES     = 10;
    localparam int DEF_MIN_GAP_CYCLES  = 8;
    localparam int DEF_CNT_W           = 4;

endpackage

// File: rtl/ped_request_unit_if.sv
// ped_request_unit_if: crossing link between the pedestrian request unit
// and the traffic light controller.
//   ped_req    - request into the controller's pedestrian_btn
//   walk_light - controller walk lamp
//   stop_light - controller stop lamp
// master = pedestrian request unit, slave = controller.
interface ped_request_unit_if;
    logic ped_req;
    logic walk_light;
    logic stop_light;

    modport master (output ped_req, input walk_light, input stop_light);
    modport slave  (input ped_req, output walk_light, output stop_light);
endinterface

// File: rtl/ped_request_unit_btn_debounce.sv
// btn_debounce: two-flop synchroniser, saturating debounce counter and a
// one-cycle pulse on the debounced rising edge.
//   clk, rst_n - clock, asynchronous active-low reset
//   btn_raw    - raw asynchronous push-button, active high
//   press_evt  - one-cycle pulse per accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press_evt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);

    logic            sync1_reg;
    logic            btn_s_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic            btn_db_d_reg;
    logic            btn_db;

    assign btn_db = (db_cnt_reg == DB_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b0;
            btn_s_reg    <= 1'b0;
            db_cnt_reg   <= '0;
            btn_db_d_reg <= 1'b0;
        end else begin
            sync1_reg    <= btn_raw;
            btn_s_reg    <= sync1_reg;
            btn_db_d_reg <= btn_db;
            // Any low sample restarts the count, so short pulses never qualify.
            if (!btn_s_reg)
                db_cnt_reg <= '0;
            else if (!btn_db)
                db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    // Holding the button keeps btn_db high, so only the first cycle pulses.
    assign press_evt = btn_db & ~btn_db_d_reg;

endmodule

// File: rtl/ped_request_unit.sv
// ped_request_unit: pedestrian-side end of the crossing interface. Debounces
// the push-button, holds a clean request into the controller, shows the walk
// countdown, enforces a cooldown gap and flags controller misbehaviour.
//   clk, rst_n     - clock, asynchronous active-low reset
//   btn_raw        - raw push-button
//   ctrl           - master side of the controller link (ped_req out,
//                    walk_light / stop_light in)
//   req_pending    - wait lamp: request outstanding or queued
//   walk_countdown - remaining walk cycles for display
//   protocol_err   - sticky controller-behaviour violation
module ped_request_unit
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
    parameter int MIN_GAP_CYCLES  = DEF_MIN_GAP_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_raw,
    ped_request_unit_if.master   ctrl,
    output logic                 req_pending,
    output logic [CNT_W-1:0]     walk_countdown,
    output logic                 protocol_err
);

    localparam int GAP_W = $clog2(MIN_GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] WALK_INIT = CNT_W'(WALK_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_INIT  = GAP_W'(MIN_GAP_CYCLES - 1);

    ped_state_e       state_reg;
    logic             ped_req_reg;
    logic             req_pending_reg;
    logic [CNT_W-1:0] walk_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             queued_reg;
    logic             protocol_err_reg;
    logic             press_evt;
    logic             err_now;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .press_evt(press_evt)
    );

    // Controller violations, judged against the current state.
    assign err_now = (ctrl.walk_light && ctrl.stop_light)
                   || (ctrl.walk_light && (state_reg == IDLE || state_reg == COOLDOWN))
                   || (!ctrl.walk_light && !ctrl.stop_light && state_reg == WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            ped_req_reg      <= 1'b0;
            req_pending_reg  <= 1'b0;
            walk_cnt_reg     <= '0;
            gap_cnt_reg      <= '0;
            queued_reg       <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            if (err_now)
                protocol_err_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (press_evt) begin
                        state_reg       <= REQUEST;
                        ped_req_reg     <= 1'b1;
                        req_pending_reg <= 1'b1;
                    end
                end
                REQUEST: begin
                    if (ctrl.walk_light) begin
                        state_reg       <= WALK;
                        ped_req_reg     <= 1'b0;
                        req_pending_reg <= 1'b0;
                        walk_cnt_reg    <= WALK_INIT;
                    end
                end
                WALK: begin
                    // The controller ends the walk; the display just bottoms out.
                    if (!ctrl.walk_light) begin
                        state_reg    <= COOLDOWN;
                        walk_cnt_reg <= '0;
                        gap_cnt_reg  <= GAP_INIT;
                    end else if (walk_cnt_reg != '0) begin
                        walk_cnt_reg <= walk_cnt_reg - 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (gap_cnt_reg == '0) begin
                        // A press in this very cycle still counts as queued.
                        queued_reg <= 1'b0;
                        if (queued_reg || press_evt) begin
                            state_reg       <= REQUEST;
                            ped_req_reg     <= 1'b1;
                            req_pending_reg <= 1'b1;
                        end else begin
                            state_reg       <= IDLE;
                            req_pending_reg <= 1'b0;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        if (press_evt) begin
                            queued_reg      <= 1'b1;
                            req_pending_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ctrl.ped_req   = ped_req_reg;
    assign req_pending    = req_pending_reg;
    assign walk_countdown = walk_cnt_reg;
    assign protocol_err   = protocol_err_reg;

endmodule

// File: tb/tb_ped_request_unit.sv
// Bench for ped_request_unit with default parameters. Expected ped_req rising
// edges (absolute clock-edge numbers) are pushed to a scoreboard when a press
// is driven; a monitor pops and compares them when the DUT raises ped_req.
module tb_ped_request_unit;
    import ped_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_raw = 1'b0;
    logic        req_pending;
    logic [3:0]  walk_countdown;
    logic        protocol_err;
    logic [31:0] cyc = 0;
    logic        ped_req_prev = 1'b0;
    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] rise_q[$];
    logic [31:0] c0;
    logic [31:0] c1;

    ped_request_unit_if ctrl_if ();

    ped_request_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .ctrl          (ctrl_if.master),
        .req_pending   (req_pending),
        .walk_countdown(walk_countdown),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, want %0d (edge %0d)", tag, obs, exp, cyc);
        end else begin
            $display("[TB] ok   %s: %0d (edge %0d)", tag, obs, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_lights(input logic w, input logic s);
        ctrl_if.walk_light = w;
        ctrl_if.stop_light = s;
    endtask

    // Scoreboard consumer: each ped_req rise must match the next expected edge.
    always @(negedge clk) begin
        if (rst_n && ctrl_if.ped_req && !ped_req_prev) begin
            if (rise_q.size() != 0)
                check("req_rise_edge", cyc, rise_q.pop_front());
            else
                check("unexpected_req", 32'd1, 32'd0);
        end
        ped_req_prev <= ctrl_if.ped_req;
    end

    initial begin
        set_lights(1'b0, 1'b1);
        tick(2);
        check("rst_ped_req", ctrl_if.ped_req, 0);
        check("rst_pending", req_pending, 0);
        check("rst_countdown", walk_countdown, 0);
        check("rst_err", protocol_err, 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press: ped_req rises at the 7th edge after btn goes high.
        c0 = cyc;
        btn_raw = 1'b1;
        rise_q.push_back(c0 + 7);
        tick(6);
        check("req_before_latency", ctrl_if.ped_req, 0);
        tick(1);
        check("req_high", ctrl_if.ped_req, 1);
        check("pending_high", req_pending, 1);
        tick(5);
        check("req_held", ctrl_if.ped_req, 1);
        btn_raw = 1'b0;
        set_lights(1'b1, 1'b0);
        tick(1);
        check("walk_req_low", ctrl_if.ped_req, 0);
        check("walk_pending_low", req_pending, 0);
        check("walk_cnt_init", walk_countdown, 9);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            check("walk_cnt", walk_countdown, (k >= 9) ? 0 : 9 - k);
        end
        check("walk_no_err", protocol_err, 0);
        set_lights(1'b0, 1'b1);
        tick(1);
        check("cool_cnt_zero", walk_countdown, 0);
        tick(10);
        check("idle_req_low", ctrl_if.ped_req, 0);
        check("idle_pending_low", req_pending, 0);

        // Glitch: 3-cycle pulse is rejected.
        btn_raw = 1'b1;
        tick(3);
        btn_raw = 1'b0;
        tick(15);
        check("glitch_req", ctrl_if.ped_req, 0);
        check("glitch_pending", req_pending, 0);

        // Held for 50 cycles: exactly one request.
        c0 = cyc;
        btn_raw = 1'b1;
        rise_q.push_back(c0 + 7);
        tick(50);
        btn_raw = 1'b0;
        check("held_one_req", rise_q.size(), 0);
        check("held_req_high", ctrl_if.ped_req, 1);

        // Walk dropped at countdown 4; press during cooldown is queued.
        set_lights(1'b1, 1'b0);
        tick(6);
        check("walk_cnt_at_drop", walk_countdown, 4);
        c1 = cyc;
        set_lights(1'b0, 1'b1);
        btn_raw = 1'b1;
        rise_q.push_back(c1 + 9);
        tick(6);
        check("queue_pending_early", req_pending, 0);
        tick(1);
        check("queue_pending", req_pending, 1);
        check("queue_req_wait", ctrl_if.ped_req, 0);
        btn_raw = 1'b0;
        tick(2);
        check("queue_req_high", ctrl_if.ped_req, 1);

        // Press landing in the final cooldown cycle is still honoured.
        set_lights(1'b1, 1'b0);
        tick(2);
        c1 = cyc;
        set_lights(1'b0, 1'b1);
        tick(2);
        btn_raw = 1'b1;
        rise_q.push_back(c1 + 9);
        tick(6);
        check("last_cool_pending", req_pending, 0);
        tick(1);
        check("last_cool_req", ctrl_if.ped_req, 1);
        btn_raw = 1'b0;

        // Cooldown without a press returns to IDLE.
        set_lights(1'b1, 1'b0);
        tick(2);
        set_lights(1'b0, 1'b1);
        tick(9);
        check("nopress_req", ctrl_if.ped_req, 0);
        check("nopress_pending", req_pending, 0);
        check("nopress_err", protocol_err, 0);
        tick(10);
        check("nopress_req_later", ctrl_if.ped_req, 0);

        // Presses during REQUEST and WALK are ignored.
        c0 = cyc;
        btn_raw = 1'b1;
        rise_q.push_back(c0 + 7);
        tick(8);
        btn_raw = 1'b0;
        tick(3);
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(2);
        check("req_press_ignored", ctrl_if.ped_req, 1);
        set_lights(1'b1, 1'b0);
        tick(1);
        btn_raw = 1'b1;
        tick(10);
        btn_raw = 1'b0;
        tick(2);
        // Both lamps dark while walking ends the walk and flags an error.
        set_lights(1'b0, 1'b0);
        tick(1);
        check("walk_dark_err", protocol_err, 1);
        set_lights(1'b0, 1'b1);
        tick(12);
        check("ignored_req", ctrl_if.ped_req, 0);
        check("ignored_pending", req_pending, 0);
        check("ignored_sb_empty", rise_q.size(), 0);

        // Asynchronous reset clears the sticky error.
        #2 rst_n = 1'b0;
        #1 check("async_rst_err", protocol_err, 0);
        tick(1);
        rst_n = 1'b1;

        // Both lamps lit for one cycle.
        set_lights(1'b1, 1'b1);
        tick(1);
        set_lights(1'b0, 1'b1);
        check("both_lamps_err", protocol_err, 1);
        tick(5);
        check("err_sticky", protocol_err, 1);
        check("err_no_req", ctrl_if.ped_req, 0);
        #2 rst_n = 1'b0;
        #1 check("rst_clears_err", protocol_err, 0);
        tick(1);
        rst_n = 1'b1;

        // Walk lamp in IDLE: error, but no state change.
        set_lights(1'b1, 1'b0);
        tick(1);
        set_lights(1'b0, 1'b1);
        check("idle_walk_err", protocol_err, 1);
        check("idle_walk_req", ctrl_if.ped_req, 0);
        check("idle_walk_cnt", walk_countdown, 0);
        c0 = cyc;
        btn_raw = 1'b1;
        rise_q.push_back(c0 + 7);
        tick(7);
        check("idle_still_idle", ctrl_if.ped_req, 1);
        btn_raw = 1'b0;

        // Reset in the middle of REQUEST aborts it immediately.
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("midreq_rst_req", ctrl_if.ped_req, 0);
        check("midreq_rst_pending", req_pending, 0);
        check("midreq_rst_cnt", walk_countdown, 0);
        check("midreq_rst_err", protocol_err, 0);
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check("post_rst_req", ctrl_if.ped_req, 0);
        check("final_sb_empty", rise_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
